// File: rtl/fifo_rd_packer.sv
// fifo_rd_packer: pops DSIZE-bit words from the read side of a dual-clock FIFO
// and packs PACK consecutive words into one registered valid/ready beat.
// A flush closes a partially filled beat and marks it with m_last.
module fifo_rd_packer #(
    parameter int unsigned DSIZE = 8,
    parameter int unsigned PACK  = 4,
    localparam int unsigned FW   = $clog2(PACK + 1)
) (
    input  logic                    rclk,
    input  logic                    rrst,
    input  logic                    rempty,
    input  logic [DSIZE-1:0]        rdata,
    output logic                    rreq,
    input  logic                    flush,
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic [DSIZE*PACK-1:0]   m_data,
    output logic [PACK-1:0]         m_keep,
    output logic                    m_last,
    output logic [FW-1:0]           acc_fill
);

    logic [DSIZE-1:0]       acc [PACK];
    logic [FW-1:0]          fill;
    logic                   flush_pend;

    logic                   ofree_c;
    logic                   full_c;
    logic                   xfer_c;
    logic                   pop_c;
    logic [FW-1:0]          lane_c;
    logic [DSIZE*PACK-1:0]  beat_data_c;
    logic [PACK-1:0]        beat_keep_c;

    assign acc_fill = fill;

    // Handshake decisions: when the accumulator moves to the output and when a word is popped.
    always_comb begin
        ofree_c = !m_valid || m_ready;
        full_c  = (fill == FW'(PACK));
        xfer_c  = ofree_c && (full_c || (flush_pend && (fill != '0)));
        pop_c   = !rrst && !rempty && !flush_pend && (!full_c || xfer_c);
        lane_c  = xfer_c ? '0 : fill;
        rreq    = pop_c;
    end

    // Beat image of the accumulator with unfilled lanes masked to zero.
    always_comb begin
        beat_data_c = '0;
        beat_keep_c = '0;
        for (int unsigned i = 0; i < PACK; i++) begin
            if (FW'(i) < fill) begin
                beat_data_c[i*DSIZE +: DSIZE] = acc[i];
                beat_keep_c[i]                = 1'b1;
            end
        end
    end

    // Accumulator lanes: a popped word lands at lane 0 when the beat leaves this cycle.
    always_ff @(posedge rclk) begin
        if (rrst) begin
            for (int unsigned i = 0; i < PACK; i++) begin
                acc[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < PACK; i++) begin
                if (pop_c && (lane_c == FW'(i))) begin
                    acc[i] <= rdata;
                end
            end
        end
    end

    // Fill count and pending-flush flag.
    always_ff @(posedge rclk) begin
        if (rrst) begin
            fill       <= '0;
            flush_pend <= 1'b0;
        end else begin
            fill <= xfer_c ? FW'(pop_c) : fill + FW'(pop_c);
            if (flush_pend) begin
                if (xfer_c || ((fill == '0) && !pop_c)) begin
                    flush_pend <= 1'b0;
                end
            end else if (flush) begin
                flush_pend <= 1'b1;
            end
        end
    end

    // Output register: loads on transfer, drops valid only on acceptance.
    always_ff @(posedge rclk) begin
        if (rrst) begin
            m_valid <= 1'b0;
            m_data  <= '0;
            m_keep  <= '0;
            m_last  <= 1'b0;
        end else if (xfer_c) begin
            m_valid <= 1'b1;
            m_data  <= beat_data_c;
            m_keep  <= beat_keep_c;
            m_last  <= flush_pend;
        end else if (m_ready) begin
            m_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fifo_rd_packer.sv
// Self-checking bench for fifo_rd_packer: FIFO modelled as a queue, beats
// captured on handshake and compared against word groupings computed here.
module tb_fifo_rd_packer;

    localparam int unsigned DSIZE = 8;
    localparam int unsigned PACK  = 4;
    localparam int unsigned FW    = $clog2(PACK + 1);

    typedef struct packed {
        logic [DSIZE*PACK-1:0] data;
        logic [PACK-1:0]       keep;
        logic                  last;
    } beat_t;

    logic                  rclk = 1'b0;
    logic                  rrst;
    logic                  rempty;
    logic [DSIZE-1:0]      rdata;
    logic                  rreq;
    logic                  flush;
    logic                  m_valid;
    logic                  m_ready;
    logic [DSIZE*PACK-1:0] m_data;
    logic [PACK-1:0]       m_keep;
    logic                  m_last;
    logic [FW-1:0]         acc_fill;

    logic [DSIZE-1:0] fifo_q [$];
    beat_t            got_q  [$];
    int               pop_cnt;
    int               n_checks;
    int               n_fail;

    fifo_rd_packer #(.DSIZE(DSIZE), .PACK(PACK)) dut (
        .rclk(rclk), .rrst(rrst), .rempty(rempty), .rdata(rdata), .rreq(rreq),
        .flush(flush), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .m_keep(m_keep), .m_last(m_last), .acc_fill(acc_fill)
    );

    always #5 rclk = ~rclk;

    // FIFO read-side model and beat capture on the active edge.
    always @(posedge rclk) begin
        logic [DSIZE-1:0] dummy;
        if (rreq && fifo_q.size() != 0) begin
            dummy = fifo_q.pop_front();
            pop_cnt++;
        end
        if (m_valid && m_ready) got_q.push_back('{m_data, m_keep, m_last});
        rempty <= (fifo_q.size() == 0);
        rdata  <= (fifo_q.size() != 0) ? fifo_q[0] : '0;
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge rclk);
    endtask

    task automatic push(input logic [DSIZE-1:0] w);
        fifo_q.push_back(w);
        rempty = 1'b0;
        rdata  = fifo_q[0];
    endtask

    task automatic do_reset();
        @(negedge rclk);
        rrst = 1'b1; flush = 1'b0; m_ready = 1'b0;
        fifo_q.delete(); rempty = 1'b1; rdata = '0;
        cyc(2);
        rrst = 1'b0;
        got_q.delete(); pop_cnt = 0;
    endtask

    function automatic beat_t make_beat(input logic [DSIZE-1:0] w [$], input int start,
                                        input int n, input logic last);
        beat_t b;
        b.data = '0;
        for (int i = 0; i < n; i++) b.data = b.data | ((DSIZE*PACK)'(w[start+i]) << (DSIZE*i));
        b.keep = PACK'((1 << n) - 1);
        b.last = last;
        return b;
    endfunction

    task automatic test_reset();
        rrst = 1'b1; flush = 1'b0; m_ready = 1'b1;
        fifo_q.delete(); rempty = 1'b1; rdata = '0; pop_cnt = 0;
        push(8'h5A);
        cyc(1);
        for (int i = 0; i < 2; i++) begin
            n_checks++; if (rreq !== 1'b0) begin n_fail++; $display("FAIL reset_rreq: got %b want 0", rreq); end
            n_checks++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", m_valid); end
            n_checks++; if (m_data !== '0) begin n_fail++; $display("FAIL reset_data: got %h want 0", m_data); end
            n_checks++; if ({m_keep, m_last, acc_fill} !== '0) begin n_fail++; $display("FAIL reset_keep_last_fill: got %h/%b/%0d want 0", m_keep, m_last, acc_fill); end
            cyc(1);
        end
        rrst = 1'b0;
        #1;
        n_checks++; if (rreq !== 1'b1) begin n_fail++; $display("FAIL reset_first_pop: got rreq %b want 1", rreq); end
        cyc(1);
        n_checks++; if (pop_cnt !== 1) begin n_fail++; $display("FAIL reset_pop_count: got %0d want 1", pop_cnt); end
    endtask

    task automatic test_back_to_back();
        int first = -1;
        int vcnt = 0;
        do_reset();
        m_ready = 1'b1;
        push(8'h11); push(8'h22); push(8'h33); push(8'h44);
        for (int k = 1; k <= 12; k++) begin
            @(negedge rclk);
            if (m_valid) begin
                vcnt++;
                if (first < 0) first = k;
            end
        end
        n_checks++; if (first !== PACK + 1) begin n_fail++; $display("FAIL b2b_latency: got cycle %0d want %0d", first, PACK + 1); end
        n_checks++; if (vcnt !== 1) begin n_fail++; $display("FAIL b2b_valid_cycles: got %0d want 1", vcnt); end
        n_checks++; if (pop_cnt !== 4) begin n_fail++; $display("FAIL b2b_pops: got %0d want 4", pop_cnt); end
        n_checks++;
        if (got_q.size() != 1) begin n_fail++; $display("FAIL b2b_beats: got %0d beats want 1", got_q.size()); end
        else if (got_q[0] !== beat_t'({32'h44332211, 4'hF, 1'b0})) begin
            n_fail++; $display("FAIL b2b_beat: got %h/%h/%b want 44332211/f/0", got_q[0].data, got_q[0].keep, got_q[0].last);
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        m_ready = 1'b0;
        for (int i = 1; i <= 8; i++) push(DSIZE'(i * 8'h11));
        cyc(20);
        n_checks++; if (m_valid !== 1'b1 || m_data !== 32'h44332211) begin n_fail++; $display("FAIL bp_hold: got %b/%h want 1/44332211", m_valid, m_data); end
        n_checks++; if (acc_fill !== FW'(4)) begin n_fail++; $display("FAIL bp_fill: got %0d want 4", acc_fill); end
        n_checks++; if (rreq !== 1'b0) begin n_fail++; $display("FAIL bp_rreq: got %b want 0", rreq); end
        n_checks++; if (pop_cnt !== 8) begin n_fail++; $display("FAIL bp_pops: got %0d want 8", pop_cnt); end
        m_ready = 1'b1;
        cyc(10);
        n_checks++;
        if (got_q.size() != 2) begin n_fail++; $display("FAIL bp_beats: got %0d beats want 2", got_q.size()); end
        else if (got_q[0].data !== 32'h44332211 || got_q[1].data !== 32'h88776655) begin
            n_fail++; $display("FAIL bp_order: got %h,%h want 44332211,88776655", got_q[0].data, got_q[1].data);
        end
    endtask

    task automatic test_partial_flush();
        do_reset();
        m_ready = 1'b1;
        push(8'hA1); push(8'hA2);
        cyc(4);
        n_checks++; if (acc_fill !== FW'(2)) begin n_fail++; $display("FAIL pf_fill: got %0d want 2", acc_fill); end
        flush = 1'b1;
        cyc(1);
        flush = 1'b0;
        push(8'hB1);
        #1;
        n_checks++; if (rreq !== 1'b0 || m_valid !== 1'b0) begin n_fail++; $display("FAIL pf_pending: got rreq %b valid %b want 0 0", rreq, m_valid); end
        cyc(1);
        n_checks++; if ({m_valid, m_data, m_keep, m_last} !== {1'b1, 32'h0000A2A1, 4'b0011, 1'b1}) begin
            n_fail++; $display("FAIL pf_beat: got %b/%h/%b/%b want 1/0000a2a1/0011/1", m_valid, m_data, m_keep, m_last);
        end
        push(8'hB2); push(8'hB3); push(8'hB4);
        cyc(8);
        n_checks++;
        if (got_q.size() != 2) begin n_fail++; $display("FAIL pf_beats: got %0d beats want 2", got_q.size()); end
        else if (got_q[1] !== beat_t'({32'hB4B3B2B1, 4'hF, 1'b0})) begin
            n_fail++; $display("FAIL pf_next_lane0: got %h/%h/%b want b4b3b2b1/f/0", got_q[1].data, got_q[1].keep, got_q[1].last);
        end
    endtask

    task automatic test_flush_empty_full();
        do_reset();
        m_ready = 1'b1;
        flush = 1'b1;
        cyc(1);
        flush = 1'b0;
        push(8'hC1);
        #1;
        n_checks++; if (rreq !== 1'b0) begin n_fail++; $display("FAIL fe_pending: got rreq %b want 0", rreq); end
        cyc(1);
        n_checks++; if (rreq !== 1'b1) begin n_fail++; $display("FAIL fe_cleared: got rreq %b want 1", rreq); end
        n_checks++; if (m_valid !== 1'b0 || got_q.size() != 0) begin n_fail++; $display("FAIL fe_no_beat: got valid %b beats %0d want 0 0", m_valid, got_q.size()); end
        cyc(1);
        n_checks++; if (acc_fill !== FW'(1)) begin n_fail++; $display("FAIL fe_fill: got %0d want 1", acc_fill); end

        do_reset();
        m_ready = 1'b0;
        for (int i = 1; i <= 8; i++) push(8'hD0 + DSIZE'(i));
        cyc(14);
        n_checks++; if (m_valid !== 1'b1 || acc_fill !== FW'(4)) begin n_fail++; $display("FAIL ff_setup: got valid %b fill %0d want 1 4", m_valid, acc_fill); end
        flush = 1'b1;
        cyc(1);
        flush = 1'b0;
        cyc(3);
        n_checks++; if (m_last !== 1'b0 || m_data !== 32'hD4D3D2D1) begin n_fail++; $display("FAIL ff_hold: got %h/%b want d4d3d2d1/0", m_data, m_last); end
        m_ready = 1'b1;
        cyc(4);
        n_checks++;
        if (got_q.size() != 2) begin n_fail++; $display("FAIL ff_beats: got %0d beats want 2", got_q.size()); end
        else if (got_q[0].last !== 1'b0 || got_q[1] !== beat_t'({32'hD8D7D6D5, 4'hF, 1'b1})) begin
            n_fail++; $display("FAIL ff_beat: got %h/%h/%b (first last %b) want d8d7d6d5/f/1", got_q[1].data, got_q[1].keep, got_q[1].last, got_q[0].last);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        m_ready = 1'b0;
        for (int i = 1; i <= 7; i++) push(8'hE0 + DSIZE'(i));
        cyc(14);
        n_checks++; if (acc_fill !== FW'(3) || m_valid !== 1'b1) begin n_fail++; $display("FAIL rm_setup: got fill %0d valid %b want 3 1", acc_fill, m_valid); end
        rrst = 1'b1;
        push(8'hEE);
        #1;
        n_checks++; if (rreq !== 1'b0) begin n_fail++; $display("FAIL rm_rreq: got %b want 0", rreq); end
        cyc(1);
        n_checks++; if ({m_valid, m_data, m_keep, m_last, acc_fill} !== '0) begin
            n_fail++; $display("FAIL rm_outputs: got %b/%h/%h/%b/%0d want all 0", m_valid, m_data, m_keep, m_last, acc_fill);
        end
        fifo_q.delete(); rempty = 1'b1; rdata = '0;
        rrst = 1'b0;
        got_q.delete();
        push(8'h01); push(8'h02); push(8'h03); push(8'h04);
        m_ready = 1'b1;
        cyc(8);
        n_checks++;
        if (got_q.size() != 1) begin n_fail++; $display("FAIL rm_beats: got %0d beats want 1", got_q.size()); end
        else if (got_q[0].data !== 32'h04030201) begin n_fail++; $display("FAIL rm_beat: got %h want 04030201", got_q[0].data); end
    endtask

    task automatic test_random();
        do_reset();
        for (int r = 0; r < 4; r++) begin
            logic [DSIZE-1:0] words [$];
            beat_t            exp_q [$];
            int nb = $urandom_range(1, 5);
            int k  = $urandom_range(1, PACK - 1);
            int pushed = 0;
            int t = 0;
            got_q.delete();
            while (pushed < nb * PACK) begin
                @(negedge rclk);
                m_ready = 1'($urandom);
                if ($urandom_range(0, 2) != 0) begin
                    logic [DSIZE-1:0] w = DSIZE'($urandom);
                    words.push_back(w);
                    push(w);
                    pushed++;
                end
            end
            for (int b = 0; b < nb; b++) exp_q.push_back(make_beat(words, b * PACK, PACK, 1'b0));
            m_ready = 1'b1;
            while (got_q.size() < nb && t < 200) begin
                cyc(1);
                t++;
            end
            n_checks++; if (got_q.size() != nb) begin n_fail++; $display("FAIL rnd_drain: round %0d got %0d beats want %0d", r, got_q.size(), nb); end
            for (int i = 0; i < k; i++) begin
                logic [DSIZE-1:0] w = DSIZE'($urandom);
                words.push_back(w);
                push(w);
            end
            cyc(k + 3);
            n_checks++; if (acc_fill !== FW'(k)) begin n_fail++; $display("FAIL rnd_tail_fill: round %0d got %0d want %0d", r, acc_fill, k); end
            flush = 1'b1;
            cyc(1);
            flush = 1'b0;
            cyc(4);
            exp_q.push_back(make_beat(words, nb * PACK, k, 1'b1));
            n_checks++; if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL rnd_count: round %0d got %0d want %0d", r, got_q.size(), exp_q.size()); end
            for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
                n_checks++;
                if (got_q[i] !== exp_q[i]) begin
                    n_fail++;
                    $display("FAIL rnd_beat: round %0d beat %0d got %h/%h/%b want %h/%h/%b", r, i,
                             got_q[i].data, got_q[i].keep, got_q[i].last, exp_q[i].data, exp_q[i].keep, exp_q[i].last);
                end
            end
        end
    endtask

    initial begin
        n_checks = 0; n_fail = 0; pop_cnt = 0;
        rrst = 1'b1; flush = 1'b0; m_ready = 1'b0; rempty = 1'b1; rdata = '0;
        test_reset();
        test_back_to_back();
        test_backpressure();
        test_partial_flush();
        test_flush_empty_full();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
